// File: rtl/datapath_core.sv
// datapath_core: 32-bit single-bus CPU datapath with PC, MAR, MDR, IR, Y, Z, R2/R4/R5 and AND/ADD/IncPC ALU.
// Optional macro DATAPATH_ZHIGH_EN: Z becomes 2*WIDTH wide (carry in Z[WIDTH]) and adds the Zhighout bus source.
module datapath_core #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             PCout,
    input  logic             Zlowout,
`ifdef DATAPATH_ZHIGH_EN
    input  logic             Zhighout,
`endif
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R4out,
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             R2in,
    input  logic             R4in,
    input  logic             R5in,
    input  logic             IncPC,
    input  logic             AND,
    input  logic             Read,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] PC_q,
    output logic [WIDTH-1:0] MAR_q,
    output logic [WIDTH-1:0] IR_q,
    output logic [WIDTH-1:0] R5_q
);

`ifdef DATAPATH_ZHIGH_EN
    localparam int unsigned ZW = 2 * WIDTH;
`else
    localparam int unsigned ZW = WIDTH;
`endif

    logic [WIDTH-1:0] mdr_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] r2_q;
    logic [WIDTH-1:0] r4_q;
    logic [ZW-1:0]    z_q;
    logic [WIDTH-1:0] mdr_d;
    logic [ZW-1:0]    z_d;
    logic [ZW-1:0]    sum;

    // Single bus: fixed-priority source select, zero when nothing drives.
    always_comb begin
        BusMuxOut = '0;
        if (R4out) begin
            BusMuxOut = r4_q;
        end else if (R2out) begin
            BusMuxOut = r2_q;
        end else if (MDRout) begin
            BusMuxOut = mdr_q;
        end else if (Zlowout) begin
            BusMuxOut = z_q[WIDTH-1:0];
`ifdef DATAPATH_ZHIGH_EN
        end else if (Zhighout) begin
            BusMuxOut = z_q[ZW-1:WIDTH];
`endif
        end else if (PCout) begin
            BusMuxOut = PC_q;
        end
    end

    // ALU: sum is ZW wide so a wide Z keeps the carry in bit WIDTH.
    always_comb begin
        sum = '0;
        if (IncPC) begin
            sum = ZW'(BusMuxOut) + ZW'(1);
        end else begin
            sum = ZW'(y_q) + ZW'(BusMuxOut);
        end
        z_d = AND ? ZW'(y_q & BusMuxOut) : sum;
    end

    // MDR source: memory on Read, otherwise the bus.
    always_comb begin
        mdr_d = Read ? Mdatain : BusMuxOut;
    end

    // Register file: each register loads on its enable, all see the pre-edge bus.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            PC_q  <= RESET_PC;
            MAR_q <= '0;
            mdr_q <= '0;
            IR_q  <= '0;
            y_q   <= '0;
            z_q   <= '0;
            r2_q  <= '0;
            r4_q  <= '0;
            R5_q  <= '0;
        end else begin
            if (PCin)  PC_q  <= BusMuxOut;
            if (MARin) MAR_q <= BusMuxOut;
            if (MDRin) mdr_q <= mdr_d;
            if (IRin)  IR_q  <= BusMuxOut;
            if (Yin)   y_q   <= BusMuxOut;
            if (Zin)   z_q   <= z_d;
            if (R2in)  r2_q  <= BusMuxOut;
            if (R4in)  r4_q  <= BusMuxOut;
            if (R5in)  R5_q  <= BusMuxOut;
        end
    end

endmodule

// File: tb/tb_datapath_core.sv
// tb_datapath_core: scoreboard bench for datapath_core.
// Directed fetch/AND/wrap/priority sequences, then random control sets vs. a reference model.
module tb_datapath_core;

    localparam int W = 32;
    localparam logic [W-1:0] RST_PC = '0;

    typedef logic [17:0] ctrl_t;
    localparam ctrl_t IDLE  = 18'h00000;
    localparam ctrl_t PCO   = 18'h00001;
    localparam ctrl_t ZLO   = 18'h00002;
    localparam ctrl_t ZHO   = 18'h00004;
    localparam ctrl_t MDRO  = 18'h00008;
    localparam ctrl_t R2O   = 18'h00010;
    localparam ctrl_t R4O   = 18'h00020;
    localparam ctrl_t MARI  = 18'h00040;
    localparam ctrl_t ZI    = 18'h00080;
    localparam ctrl_t PCI   = 18'h00100;
    localparam ctrl_t MDRI  = 18'h00200;
    localparam ctrl_t IRI   = 18'h00400;
    localparam ctrl_t YI    = 18'h00800;
    localparam ctrl_t R2I   = 18'h01000;
    localparam ctrl_t R4I   = 18'h02000;
    localparam ctrl_t R5I   = 18'h04000;
    localparam ctrl_t INC   = 18'h08000;
    localparam ctrl_t ANDOP = 18'h10000;
    localparam ctrl_t RD    = 18'h20000;

    typedef struct {
        string        tag;
        logic [W-1:0] bus;
        logic [W-1:0] pc;
        logic [W-1:0] mar;
        logic [W-1:0] ir;
        logic [W-1:0] r5;
    } exp_t;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic         PCout, Zlowout, MDRout, R2out, R4out;
`ifdef DATAPATH_ZHIGH_EN
    logic         Zhighout;
`endif
    logic         MARin, Zin, PCin, MDRin, IRin, Yin, R2in, R4in, R5in;
    logic         IncPC, op_and, Read;
    logic [W-1:0] Mdatain;
    logic [W-1:0] BusMuxOut, PC_q, MAR_q, IR_q, R5_q;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: architectural registers, Z held 64 bits wide.
    logic [W-1:0]   m_pc, m_mar, m_mdr, m_ir, m_y, m_r2, m_r4, m_r5;
    logic [2*W-1:0] m_z;

    always #5 Clock = ~Clock;

    datapath_core #(.WIDTH(W), .RESET_PC(RST_PC)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .PCout     (PCout),
        .Zlowout   (Zlowout),
`ifdef DATAPATH_ZHIGH_EN
        .Zhighout  (Zhighout),
`endif
        .MDRout    (MDRout),
        .R2out     (R2out),
        .R4out     (R4out),
        .MARin     (MARin),
        .Zin       (Zin),
        .PCin      (PCin),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .R2in      (R2in),
        .R4in      (R4in),
        .R5in      (R5in),
        .IncPC     (IncPC),
        .AND       (op_and),
        .Read      (Read),
        .Mdatain   (Mdatain),
        .BusMuxOut (BusMuxOut),
        .PC_q      (PC_q),
        .MAR_q     (MAR_q),
        .IR_q      (IR_q),
        .R5_q      (R5_q)
    );

    function automatic bit on(input ctrl_t c, input ctrl_t m);
        return (c & m) != '0;
    endfunction

    task automatic model_reset();
        m_pc  = RST_PC;
        m_mar = '0;
        m_mdr = '0;
        m_ir  = '0;
        m_y   = '0;
        m_r2  = '0;
        m_r4  = '0;
        m_r5  = '0;
        m_z   = '0;
    endtask

    function automatic logic [W-1:0] model_bus(input ctrl_t c);
        if (on(c, R4O))  return m_r4;
        if (on(c, R2O))  return m_r2;
        if (on(c, MDRO)) return m_mdr;
        if (on(c, ZLO))  return m_z[W-1:0];
`ifdef DATAPATH_ZHIGH_EN
        if (on(c, ZHO))  return m_z[2*W-1:W];
`endif
        if (on(c, PCO))  return m_pc;
        return '0;
    endfunction

    function automatic logic [2*W-1:0] model_alu(input ctrl_t c, input logic [W-1:0] b);
        longint unsigned a;
        longint unsigned bb;
        longint unsigned r;
        a  = 64'(m_y);
        bb = 64'(b);
        if (on(c, ANDOP))    r = a & bb;
        else if (on(c, INC)) r = bb + 1;
        else                 r = a + bb;
`ifdef DATAPATH_ZHIGH_EN
        return r;
`else
        return {32'h0, r[31:0]};
`endif
    endfunction

    task automatic apply(input ctrl_t c, input logic [W-1:0] md);
        PCout    = on(c, PCO);
        Zlowout  = on(c, ZLO);
`ifdef DATAPATH_ZHIGH_EN
        Zhighout = on(c, ZHO);
`endif
        MDRout   = on(c, MDRO);
        R2out    = on(c, R2O);
        R4out    = on(c, R4O);
        MARin    = on(c, MARI);
        Zin      = on(c, ZI);
        PCin     = on(c, PCI);
        MDRin    = on(c, MDRI);
        IRin     = on(c, IRI);
        Yin      = on(c, YI);
        R2in     = on(c, R2I);
        R4in     = on(c, R4I);
        R5in     = on(c, R5I);
        IncPC    = on(c, INC);
        op_and   = on(c, ANDOP);
        Read     = on(c, RD);
        Mdatain  = md;
    endtask

    // One control cycle: expect the current state, then advance the model past the edge.
    task automatic step(input ctrl_t c, input logic [W-1:0] md, input string tag);
        logic [W-1:0]   b;
        logic [2*W-1:0] zn;
        @(posedge Clock);
        #1;
        apply(c, md);
        b  = model_bus(c);
        zn = model_alu(c, b);
        sbq.push_back('{tag, b, m_pc, m_mar, m_ir, m_r5});
        if (on(c, PCI))  m_pc  = b;
        if (on(c, MARI)) m_mar = b;
        if (on(c, MDRI)) m_mdr = on(c, RD) ? md : b;
        if (on(c, IRI))  m_ir  = b;
        if (on(c, YI))   m_y   = b;
        if (on(c, ZI))   m_z   = zn;
        if (on(c, R2I))  m_r2  = b;
        if (on(c, R4I))  m_r4  = b;
        if (on(c, R5I))  m_r5  = b;
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic reset_mid(input string tag);
        @(posedge Clock);
        #1;
        apply(IDLE, '0);
        Resetn = 1'b0;
        model_reset();
        sbq.push_back('{tag, '0, RST_PC, '0, '0, '0});
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
    endtask

    task automatic chk(input string tag, input string f,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", tag, f, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk(e.tag, "bus", BusMuxOut, e.bus);
                chk(e.tag, "pc",  PC_q,      e.pc);
                chk(e.tag, "mar", MAR_q,     e.mar);
                chk(e.tag, "ir",  IR_q,      e.ir);
                chk(e.tag, "r5",  R5_q,      e.r5);
            end
        end
    end

    initial begin
        ctrl_t        c;
        logic [W-1:0] md;
        apply(IDLE, '0);
        Resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;

        step(IDLE, '0, "rst_state");

        step(RD | MDRI, 32'h22, "ld22");
        step(MDRO | R2I, '0, "r2");
        step(RD | MDRI, 32'h24, "ld24");
        step(MDRO | R4I, '0, "r4");
        step(RD | MDRI, 32'h26, "ld26");
        step(MDRO | R5I, '0, "r5");

        step(PCO | MARI | INC | ZI, '0, "T0");
        step(ZLO | PCI | RD | MDRI, 32'h4A92_0000, "T1");
        step(MDRO | IRI, '0, "T2");
        step(R2O | YI, '0, "T3");
        step(R4O | ANDOP | ZI, '0, "T4");
        step(ZLO | R5I, '0, "T5");
        step(IDLE, '0, "and_done");

        step(RD | MDRI, 32'hFFFF_FFFF, "ldff");
        step(MDRO | YI, '0, "y_ff");
        step(RD | MDRI, 32'h2, "ld2");
        step(MDRO | ZI, '0, "add_wrap");
        step(ZLO, '0, "zlo_add");
        step(ZHO, '0, "zhi_add");

        step(RD | MDRI, 32'hFFFF_FFFF, "ldff2");
        step(MDRO | PCI, '0, "pc_ff");
        step(PCO | INC | ZI, '0, "inc_wrap");
        step(ZLO, '0, "zlo_inc");
        step(ZHO, '0, "zhi_inc");

        step(R2O | MDRO, '0, "prio_r2");
        step(R4O | R2O | MDRO | ZLO | PCO, '0, "prio_r4");
        step(MDRO | ZLO | PCO, '0, "prio_mdr");
        step(ZLO | PCO, '0, "prio_z");
        step(YI, '0, "idle_y");
        step(MDRO | ZI, '0, "y_zero");
        step(ZLO | R5I, '0, "y_chk");

        reset_mid("reset_mid");
        step(IDLE, '0, "post_rst");
        step(ZLO, '0, "z_cleared");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset_mid("rnd_rst");
            end else begin
                c  = ctrl_t'($urandom);
                md = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                step(c, md, "rnd");
            end
        end

        step(IDLE, '0, "final");
        repeat (3) @(posedge Clock);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- 32-bit single-bus CPU datapath.
- Contains PC, MAR, MDR, IR, Y, Z and general registers R2, R4, R5, plus a small ALU (AND, ADD, PC increment).
- All control strobes come from an external control unit (or bench) one clock at a time, so it can execute fetch (T0–T2) and a three-cycle ALU instruction (T3–T5).
- Memory data enters through Mdatain.

Parameters:
- WIDTH, 32, bus/register width
- RESET_PC, 0, PC value after reset

Ports:
- Clock  in  1  system clock, rising-edge active
- Resetn  in  1  asynchronous active-low reset
- PCout, Zlowout, MDRout, R2out, R4out  in  1 each  bus-driver selects
- MARin, Zin, PCin, MDRin, IRin, Yin, R2in, R4in, R5in  in  1 each  register load enables
- IncPC  in  1  ALU op: bus + 1
- AND  in  1  ALU op: Y AND bus
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus
- Mdatain  in  WIDTH  memory read data
- BusMuxOut  out  WIDTH  current bus value
- PC_q, MAR_q, IR_q, R5_q  out  WIDTH  register observation

Behaviour:
- Reset (Resetn=0, asynchronous):
  - all registers (MDR, MAR, IR, Y, Z, R2, R4, R5) cleared to 0; PC set to RESET_PC.
  - Hold while low; resume on the first rising edge after release.
- Bus: combinational mux, priority R4out > R2out > MDRout > Zlowout > PCout.
  - Drives the highest-priority asserted source; drives 0 when none is asserted.
  - Never tri-stated.
- ALU (combinational, A = Y, B = bus):
  - AND=1: A & B.
  - Else IncPC=1: B + 1.
  - Else: A + B (ADD).
  - Wrap-around modulo 2^WIDTH; carry discarded.
- Register load: on rising Clock, each register with its *in enable high captures its input.
  - PC, MAR, IR, Y, R2, R4, R5 capture the bus.
  - Z captures the ALU result.
  - MDR captures Mdatain when Read=1, else the bus.
  - Enable low = hold.
- A register may be both bus source and destination in one cycle; it captures the pre-edge bus value.
- Multiple in-enables in one cycle all load the same bus value.
- Outputs PC_q, MAR_q, IR_q, R5_q reflect register contents directly, no added latency.
- BusMuxOut is combinational, same cycle.
- Reference sequences (one control set per cycle, deasserted otherwise):
  - Fetch: T0 PCout,MARin,IncPC,Zin; T1 Zlowout,PCin,Read,MDRin; T2 MDRout,IRin.
  - AND: T3 R2out,Yin; T4 R4out,AND,Zin; T5 Zlowout,R5in.
  - Latency: result visible in R5 one edge after T5.

Optional Feature:
- DATAPATH_ZHIGH_EN defined:
  - Z widened to 2*WIDTH; adds input Zhighout, priority just below Zlowout.
  - IncPC/ADD carry-out goes to Z bit WIDTH, upper bits otherwise 0; AND clears Zhigh.
  - Zlowout drives Z[WIDTH-1:0]; Zhighout drives Z[2*WIDTH-1:WIDTH].
- Undefined: Z is WIDTH bits; no Zhighout port; carry discarded.

Test Plan:
- Reset: assert Resetn=0 mid-run with regs nonzero -> PC_q, MAR_q, IR_q, R5_q = 0 immediately, without a clock edge.
- Register load:
  - Mdatain=0x22, Read+MDRin one cycle, then MDRout+R2in -> R2=0x22.
  - Same with 0x24 -> R4; 0x26 -> R5_q=0x26.
- Fetch from PC=0:
  - T0 -> MAR_q=0, Z=1.
  - T1 with Mdatain=0x4A920000 -> PC_q=1, MDR=0x4A920000.
  - T2 -> IR_q=0x4A920000.
- AND R5,R2,R4 (0x22, 0x24): T3–T5 -> R5_q=0x00000020.
- ADD / wrap-around:
  - Y=0xFFFFFFFF, bus=0x00000002, Zin with no op -> Z=0x00000001.
  - IncPC with PC=0xFFFFFFFF -> Z=0.
  - With DATAPATH_ZHIGH_EN: Zhigh=1 in both cases.
- Bus priority/idle:
  - R2out and MDRout together -> BusMuxOut = R2.
  - No drivers asserted -> BusMuxOut = 0; Yin then loads Y=0.
